imm_field_decode: RTL and testbench
===================================

Name: imm_field_decode

Overview:
Pipelined immediate-field decoder between instruction fetch and the immediate extender. It accepts raw RV32I instruction words over a valid/ready handshake and classifies each one by format. For each instruction it produces the packed 20-bit immediate field, the 2-bit extension-mode control and a post-extension shift code, in the exact form the extender consumes. A 2-entry output buffer decouples fetch stalls from decode stalls, so instr_ready never depends combinationally on imm_ready.

Parameters:
DEPTH, 2, output buffer entries (fixed at 2; the count register is 2 bits)
RESET_ZERO, 1, when 1, buffered payload registers clear on reset; when 0, only valid/count clear

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush (branch redirect); discards all buffered entries
instr_valid  input  1  instr holds a valid word
instr_ready  output  1  decoder can accept this cycle
instr  input  32  raw instruction word
imm_valid  output  1  head entry valid
imm_ready  input  1  consumer accepts the head entry
imm_field  output  20  packed immediate, feeds the extender's 20-bit input
imm_ext_en  output  2  00 signed12, 01 signed20, 10 unsigned12, 11 unsigned20
imm_shift  output  2  00 none, 01 shift left 1, 10 shift left 12, 11 reserved
no_imm  output  1  format carries no immediate
illegal  output  1  opcode not recognised

Behaviour:
- Accept condition: push = instr_valid & instr_ready & ~flush.
- Retire condition: pop = imm_valid & imm_ready.
- instr_ready = (count < 2), registered-state derived only.
- imm_valid = (count != 0).
- Decode happens combinationally at the input; the result is written into the buffer tail on push.
- Latency: with the buffer empty, a word accepted in cycle N appears on the outputs in cycle N+1.
- Output ports always show the head entry. Order is FIFO.
- Decode by opcode instr[6:0], in priority order:
  - 0010011 with funct3 001 or 101 (shifts): field = {8'b0, 7'b0, instr[24:20]}, ext 10, shift 00.
  - 0010011 other, 0000011, 1100111 (I-type): field[11:0] = instr[31:20], ext 00, shift 00.
  - 0100011 (S-type): field[11:0] = {instr[31:25], instr[11:7]}, ext 00, shift 00.
  - 1100011 (B-type): field[11:0] = imm[12:1] = {instr[31], instr[7], instr[30:25], instr[11:8]}, ext 00, shift 01.
  - 0110111, 0010111 (U-type): field = instr[31:12], ext 11, shift 10.
  - 1101111 (J-type): field = imm[20:1] = {instr[31], instr[19:12], instr[20], instr[30:21]}, ext 01, shift 01.
  - 0110011, 0001111, 1110011: field 0, ext 00, shift 00, no_imm = 1.
  - Anything else: field 0, ext 00, shift 00, illegal = 1.
- Field bits [19:12] are 0 for every 12-bit format.
- Count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together (count = 1 only; at count 2 push is blocked): count unchanged; the new entry becomes head in the next cycle.
- Full (count = 2): instr_ready = 0. Pop frees a slot; instr_ready rises the following cycle.
- Empty: imm_valid = 0. Outputs hold the last head payload (or zero if RESET_ZERO = 1 and nothing was ever written).
- Read/write pointers are 1 bit each and wrap 1 → 0.
- flush: count ← 0, pointers ← 0 on the next edge. It overrides a simultaneous push and pop; the word on instr in that cycle is dropped.
- Reset (asynchronous, any time including mid-handshake):
  - count = 0, pointers = 0.
  - imm_valid = 0, instr_ready = 1 once rst deasserts.
  - imm_field = 0, imm_ext_en = 00, imm_shift = 00, no_imm = 0, illegal = 0.
  - In-flight entries are discarded.
- Payloads are never modified while buffered. Outputs stay stable while imm_valid & ~imm_ready.

Test Plan:
- Reset, then push 0xFFF00093 (addi x1,x0,-1) with imm_ready = 1 → next cycle imm_valid = 1, field 0x00FFF, ext 00, shift 00, no_imm 0.
- Push 0x123450B7 (lui), then 0xFFDFF06F (jal −4), then 0x00000463 (beq +8) → in order: 0x12345/11/10; 0xFFFFE/01/01; 0x00004/00/01.
- Push 0x00309093 (slli 3) → field 0x00003, ext 10. Push 0x00000033 (add) → no_imm 1. Push 0x0000007F → illegal 1, field 0.
- Hold imm_ready = 0 and push 3 words → instr_ready falls after the 2nd; the 3rd is held. Raise imm_ready → entries 1, 2, 3 emerge in order, no loss or duplication.
- Count = 1 with simultaneous push/pop for 10 cycles → imm_valid stays 1, one result per cycle, count stays 1.
- Assert flush with count = 2 and a concurrent push → next cycle imm_valid = 0, instr_ready = 1. Assert rst mid-stream → outputs zero immediately, no stale entry appears after release.

Source files
------------

// File: rtl/imm_field_decode.sv
// RV32I immediate-field decoder with a 2-entry output FIFO feeding the immediate extender.
// The decode is combinational at the input; the buffered payload is what the outputs show.
module imm_field_decode #(
  parameter int DEPTH      = 2,
  parameter bit RESET_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        imm_valid,
  input  logic        imm_ready,
  output logic [19:0] imm_field,
  output logic [1:0]  imm_ext_en,
  output logic [1:0]  imm_shift,
  output logic        no_imm,
  output logic        illegal
);

  logic [1:0]  r_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [25:0] r_mem [2];

  logic        w_push;
  logic        w_pop;
  logic [19:0] w_field;
  logic [1:0]  w_ext;
  logic [1:0]  w_shift;
  logic        w_no_imm;
  logic        w_illegal;
  logic [25:0] w_dec;
  logic [25:0] w_head;

  assign instr_ready = (r_count < 2'(DEPTH));
  assign imm_valid   = (r_count != 2'd0);
  assign w_push      = instr_valid & instr_ready & ~flush;
  assign w_pop       = imm_valid & imm_ready;

  // Format classification and field packing of the incoming word
  always_comb begin
    w_field   = 20'd0;
    w_ext     = 2'b00;
    w_shift   = 2'b00;
    w_no_imm  = 1'b0;
    w_illegal = 1'b0;
    case (instr[6:0])
      7'b0010011: begin
        if ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101)) begin
          w_field = {15'd0, instr[24:20]};
          w_ext   = 2'b10;
        end else begin
          w_field = {8'd0, instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: w_field = {8'd0, instr[31:20]};
      7'b0100011: w_field = {8'd0, instr[31:25], instr[11:7]};
      7'b1100011: begin
        w_field = {8'd0, instr[31], instr[7], instr[30:25], instr[11:8]};
        w_shift = 2'b01;
      end
      7'b0110111, 7'b0010111: begin
        w_field = instr[31:12];
        w_ext   = 2'b11;
        w_shift = 2'b10;
      end
      7'b1101111: begin
        w_field = {instr[31], instr[19:12], instr[20], instr[30:21]};
        w_ext   = 2'b01;
        w_shift = 2'b01;
      end
      7'b0110011, 7'b0001111, 7'b1110011: w_no_imm = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_dec = {w_illegal, w_no_imm, w_shift, w_ext, w_field};

  // Occupancy and pointers; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (RESET_ZERO) begin : g_payload_rz
      // Payload storage, cleared on reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_mem[0] <= 26'd0;
          r_mem[1] <= 26'd0;
        end else if (w_push) begin
          r_mem[r_wr_ptr] <= w_dec;
        end
      end
    end else begin : g_payload_nrz
      // Payload storage without reset
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
      end
    end
  endgenerate

  assign w_head     = r_mem[r_rd_ptr];
  assign imm_field  = w_head[19:0];
  assign imm_ext_en = w_head[21:20];
  assign imm_shift  = w_head[23:22];
  assign no_imm     = w_head[24];
  assign illegal    = w_head[25];

endmodule

// File: tb/tb_imm_field_decode.sv
// Bench for imm_field_decode: directed test-plan items plus randomized traffic
// against an architectural-immediate reference model and a FIFO scoreboard.
module tb_imm_field_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'd0;
  logic        imm_valid;
  logic        imm_ready = 1'b0;
  logic [19:0] imm_field;
  logic [1:0]  imm_ext_en;
  logic [1:0]  imm_shift;
  logic        no_imm;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [25:0] q[$];

  imm_field_decode dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .imm_valid(imm_valid), .imm_ready(imm_ready),
    .imm_field(imm_field), .imm_ext_en(imm_ext_en), .imm_shift(imm_shift),
    .no_imm(no_imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: rebuild the architectural immediate, then derive the packed field from it.
  function automatic logic [25:0] ref_decode(input logic [31:0] w);
    logic [31:0] imm;
    logic [19:0] fld;
    logic [1:0]  ext, sh;
    logic        ni, il;
    logic [2:0]  f3;
    fld = 20'd0; ext = 2'd0; sh = 2'd0; ni = 1'b0; il = 1'b0;
    f3 = w[14:12];
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (w[6:0] == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
          fld = 20'(w[24:20]);
          ext = 2'b10;
        end else begin
          imm = $unsigned($signed(w) >>> 20);
          fld = 20'(imm & 32'hFFF);
        end
      end
      7'b0100011: begin
        imm = $unsigned(($signed(w) >>> 25) <<< 5) | 32'(w[11:7]);
        fld = 20'(imm & 32'hFFF);
      end
      7'b1100011: begin
        imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        fld = 20'((imm >> 1) & 32'hFFF);
        sh  = 2'b01;
      end
      7'b0110111, 7'b0010111: begin
        imm = w & 32'hFFFF_F000;
        fld = 20'(imm >> 12);
        ext = 2'b11; sh = 2'b10;
      end
      7'b1101111: begin
        imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        fld = 20'((imm >> 1) & 32'hFFFFF);
        ext = 2'b01; sh = 2'b01;
      end
      7'b0110011, 7'b0001111, 7'b1110011: ni = 1'b1;
      default: il = 1'b1;
    endcase
    return {il, ni, sh, ext, fld};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111, 7'b1110011};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 32'(imm_valid), 32'(q.size() != 0));
    chk({tag, "_ready"}, 32'(instr_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk({tag, "_field"}, 32'(imm_field), 32'(q[0][19:0]));
      chk({tag, "_ext"}, 32'(imm_ext_en), 32'(q[0][21:20]));
      chk({tag, "_shift"}, 32'(imm_shift), 32'(q[0][23:22]));
      chk({tag, "_noimm"}, 32'(no_imm), 32'(q[0][24]));
      chk({tag, "_illegal"}, 32'(illegal), 32'(q[0][25]));
    end
  endtask

  // One cycle: drive at the falling edge, update the model at the rising edge, check after.
  task automatic step(input logic v, input logic [31:0] w, input logic rd, input logic fl,
                      input string tag);
    logic push, pop;
    instr_valid = v; instr = w; imm_ready = rd; flush = fl;
    push = v && (q.size() < 2) && !fl;
    pop  = rd && (q.size() != 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_decode(w));
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic head_is(input string tag, input logic [19:0] f, input logic [1:0] e,
                         input logic [1:0] s, input logic ni, input logic il);
    chk({tag, "_v"}, 32'(imm_valid), 32'd1);
    chk({tag, "_f"}, 32'(imm_field), 32'(f));
    chk({tag, "_e"}, 32'(imm_ext_en), 32'(e));
    chk({tag, "_s"}, 32'(imm_shift), 32'(s));
    chk({tag, "_n"}, 32'(no_imm), 32'(ni));
    chk({tag, "_i"}, 32'(illegal), 32'(il));
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(imm_valid), 32'd0);
    chk({tag, "_field"}, 32'(imm_field), 32'd0);
    chk({tag, "_ext"}, 32'(imm_ext_en), 32'd0);
    chk({tag, "_shift"}, 32'(imm_shift), 32'd0);
    chk({tag, "_flags"}, 32'({no_imm, illegal}), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    zero_outputs("rst");
    rst = 1'b0;
    #1 chk("rst_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);

    step(1'b1, 32'hFFF00093, 1'b1, 1'b0, "addi"); head_is("addi", 20'h00FFF, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'h123450B7, 1'b1, 1'b0, "lui");  head_is("lui", 20'h12345, 2'b11, 2'b10, 1'b0, 1'b0);
    step(1'b1, 32'hFFDFF06F, 1'b1, 1'b0, "jal");  head_is("jal", 20'hFFFFE, 2'b01, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'h00000463, 1'b1, 1'b0, "beq");  head_is("beq", 20'h00004, 2'b00, 2'b01, 1'b0, 1'b0);
    step(1'b1, 32'h00309093, 1'b1, 1'b0, "slli"); head_is("slli", 20'h00003, 2'b10, 2'b00, 1'b0, 1'b0);
    step(1'b1, 32'h00000033, 1'b1, 1'b0, "add");  head_is("add", 20'h00000, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b1, 32'h0000007F, 1'b1, 1'b0, "ill");  head_is("ill", 20'h00000, 2'b00, 2'b00, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, "drain");

    // Backpressure: third word waits until a slot frees
    step(1'b1, 32'h00100093, 1'b0, 1'b0, "bp1");
    step(1'b1, 32'h00200113, 1'b0, 1'b0, "bp2");
    chk("bp_full_ready", 32'(instr_ready), 32'd0);
    step(1'b1, 32'h00300193, 1'b0, 1'b0, "bp3");
    step(1'b1, 32'h00300193, 1'b1, 1'b0, "bp4");
    step(1'b1, 32'h00300193, 1'b1, 1'b0, "bp5");
    chk("bp_third_head", 32'(imm_field), 32'h3);
    step(1'b0, 32'd0, 1'b1, 1'b0, "bp6");

    // Streaming at occupancy 1
    step(1'b1, rand_instr(), 1'b0, 1'b0, "st0");
    for (int i = 0; i < 10; i++) step(1'b1, rand_instr(), 1'b1, 1'b0, "stream");

    // Flush with a full buffer and a concurrent push
    step(1'b1, rand_instr(), 1'b0, 1'b0, "fl0");
    chk("fl_full", 32'(instr_ready), 32'd0);
    step(1'b1, rand_instr(), 1'b1, 1'b1, "flush");
    chk("fl_empty", 32'(imm_valid), 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, "fl_after");

    // Asynchronous reset mid-stream
    step(1'b1, 32'h123450B7, 1'b0, 1'b0, "rs0");
    step(1'b1, 32'hFFDFF06F, 1'b0, 1'b0, "rs1");
    rst = 1'b1; instr_valid = 1'b0;
    #1 zero_outputs("midrst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'd0, 1'b1, 1'b0, "post_rst");
    step(1'b0, 32'd0, 1'b1, 1'b0, "post_rst2");

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 30) == 0), "rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
